// File: rtl/vga_timing_pkg.sv
// 800x600@60 timing constants, counter widths and 1:5:5:5 to 10-bit colour expansion.
package vga_timing_pkg;

    localparam int unsigned VGA_H_ACTIVE = 800;
    localparam int unsigned VGA_H_FP     = 40;
    localparam int unsigned VGA_H_SYNC   = 128;
    localparam int unsigned VGA_H_BP     = 88;
    localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int unsigned VGA_V_ACTIVE = 600;
    localparam int unsigned VGA_V_FP     = 1;
    localparam int unsigned VGA_V_SYNC   = 4;
    localparam int unsigned VGA_V_BP     = 23;
    localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int unsigned H_W = 11;
    localparam int unsigned V_W = 10;

    // Replicating the 5-bit field keeps full-scale at full-scale (1F -> 3FF).
    function automatic logic [29:0] expand_rgb(input logic [15:0] px);
        return {px[14:10], px[14:10], px[9:5], px[9:5], px[4:0], px[4:0]};
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// DEPTH x WIDTH shift register aligning timing flags with the pixel fetch latency.
module vga_sync_delay #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_generator.sv
// Raster counters, timing decode, pixel fetch request and aligned DAC/sync output register.
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE      = VGA_H_ACTIVE,
    parameter int unsigned H_FP          = VGA_H_FP,
    parameter int unsigned H_SYNC        = VGA_H_SYNC,
    parameter int unsigned H_BP          = VGA_H_BP,
    parameter int unsigned V_ACTIVE      = VGA_V_ACTIVE,
    parameter int unsigned V_FP          = VGA_V_FP,
    parameter int unsigned V_SYNC        = VGA_V_SYNC,
    parameter int unsigned V_BP          = VGA_V_BP,
    parameter bit          HS_POL        = 1'b1,
    parameter bit          VS_POL        = 1'b1,
    parameter int unsigned PIXEL_LATENCY = 1
) (
    input  logic        VGA_CLK,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] pixel_in,
    output logic        read_pixel,
    output logic        frame_start,
    output logic [9:0]  VGA_R,
    output logic [9:0]  VGA_G,
    output logic [9:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N
);

    localparam logic [H_W-1:0] H_ACT   = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_BEG  = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END  = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [H_W-1:0] H_LAST  = H_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [V_W-1:0] V_ACT   = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_BEG  = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END  = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [V_W-1:0] V_LAST  = V_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic           halt;
    logic           run_q;
    logic [H_W-1:0] h_q, h_d;
    logic [V_W-1:0] v_q, v_d;
    logic           active_d, hs_d, vs_d, fs_d;
    logic           read_pixel_q, frame_start_q, hs_raw_q, vs_raw_q;
    logic [2:0]     dly;
    logic [29:0]    rgb;

    assign halt = reset || !enable;

    // The first running edge emits (0,0); later edges advance the raster.
    always_comb begin
        h_d = '0;
        v_d = '0;
        if (run_q) begin
            if (h_q == H_LAST) begin
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
                v_d = v_q;
            end
        end
        active_d = (h_d < H_ACT) && (v_d < V_ACT);
        hs_d     = (h_d >= HS_BEG) && (h_d < HS_END);
        vs_d     = (v_d >= VS_BEG) && (v_d < VS_END);
        fs_d     = (h_d == '0) && (v_d == V_ACT);
    end

    always_ff @(posedge VGA_CLK) begin
        if (halt) begin
            run_q         <= 1'b0;
            h_q           <= '0;
            v_q           <= '0;
            read_pixel_q  <= 1'b0;
            frame_start_q <= 1'b0;
            hs_raw_q      <= 1'b0;
            vs_raw_q      <= 1'b0;
        end else begin
            run_q         <= 1'b1;
            h_q           <= h_d;
            v_q           <= v_d;
            read_pixel_q  <= active_d;
            frame_start_q <= fs_d;
            hs_raw_q      <= hs_d;
            vs_raw_q      <= vs_d;
        end
    end

    vga_sync_delay #(
        .DEPTH (PIXEL_LATENCY),
        .WIDTH (3)
    ) u_sync_delay (
        .clk_i (VGA_CLK),
        .rst_i (halt),
        .d_i   ({read_pixel_q, hs_raw_q, vs_raw_q}),
        .q_o   (dly)
    );

    assign rgb = expand_rgb(pixel_in);

    always_ff @(posedge VGA_CLK) begin
        if (halt) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_BLANK_N <= 1'b0;
            VGA_HS      <= !HS_POL;
            VGA_VS      <= !VS_POL;
        end else begin
            VGA_R       <= dly[2] ? rgb[29:20] : '0;
            VGA_G       <= dly[2] ? rgb[19:10] : '0;
            VGA_B       <= dly[2] ? rgb[9:0]   : '0;
            VGA_BLANK_N <= dly[2];
            VGA_HS      <= dly[1] ? HS_POL : !HS_POL;
            VGA_VS      <= dly[0] ? VS_POL : !VS_POL;
        end
    end

    assign read_pixel  = read_pixel_q;
    assign frame_start = frame_start_q;
    assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Checks full-size and shrunken-timing instances cycle by cycle against an arithmetic raster model.
module tb_vga_timing_generator;

    typedef struct packed {
        logic       rp;
        logic       fs;
        logic       hs;
        logic       vs;
        logic       bn;
        logic       sn;
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } pins_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] pixel_in = '0;

    logic        b_rp, b_fs, b_hs, b_vs, b_bn, b_sn;
    logic [9:0]  b_r, b_g, b_b;
    logic        s_rp, s_fs, s_hs, s_vs, s_bn, s_sn;
    logic [9:0]  s_r, s_g, s_b;

    int errors = 0;
    int checks = 0;
    int t = -1;

    always #5 clk = ~clk;

    vga_timing_generator dut (
        .VGA_CLK(clk), .reset(reset), .enable(enable), .pixel_in(pixel_in),
        .read_pixel(b_rp), .frame_start(b_fs), .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b),
        .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_bn), .VGA_SYNC_N(b_sn)
    );

    vga_timing_generator #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIXEL_LATENCY(1)
    ) dut_s (
        .VGA_CLK(clk), .reset(reset), .enable(enable), .pixel_in(pixel_in),
        .read_pixel(s_rp), .frame_start(s_fs), .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b),
        .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_BLANK_N(s_bn), .VGA_SYNC_N(s_sn)
    );

    // tc: cycles since the raster started (-1 = halted); px: pixel sampled this edge.
    function automatic pins_t model(int tc, logic [15:0] px,
                                    int ha, int hf, int hsy, int hb,
                                    int va, int vf, int vsy, int vb);
        pins_t p;
        int ht, vt, h, v;
        logic act;
        p = '0;
        if (tc < 0) return p;
        ht = ha + hf + hsy + hb;
        vt = va + vf + vsy + vb;
        h = tc % ht;
        v = (tc / ht) % vt;
        p.rp = (h < ha) && (v < va);
        p.fs = (h == 0) && (v == va);
        if (tc >= 2) begin
            h = (tc - 2) % ht;
            v = ((tc - 2) / ht) % vt;
            act  = (h < ha) && (v < va);
            p.bn = act;
            p.hs = (h >= ha + hf) && (h < ha + hf + hsy);
            p.vs = (v >= va + vf) && (v < va + vf + vsy);
            if (act) begin
                p.r = {px[14:10], px[14:10]};
                p.g = {px[9:5], px[9:5]};
                p.b = {px[4:0], px[4:0]};
            end
        end
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s t=%0d: observed %h expected %h", tag, t, got, exp);
        end
    endtask

    task automatic cycle(input logic rst, input logic en, input logic [15:0] px);
        pins_t ob, os;
        reset    = rst;
        enable   = en;
        pixel_in = px;
        @(posedge clk);
        #1;
        t = (reset || !enable) ? -1 : t + 1;
        ob = '{rp:b_rp, fs:b_fs, hs:b_hs, vs:b_vs, bn:b_bn, sn:b_sn, r:b_r, g:b_g, b:b_b};
        os = '{rp:s_rp, fs:s_fs, hs:s_hs, vs:s_vs, bn:s_bn, sn:s_sn, r:s_r, g:s_g, b:s_b};
        chk("pins_800x600", 64'(ob), 64'(model(t, pixel_in, 800, 40, 128, 88, 600, 1, 4, 23)));
        chk("pins_small", 64'(os), 64'(model(t, pixel_in, 8, 2, 3, 2, 4, 1, 2, 1)));
    endtask

    initial begin
        int bhs, brp, run, maxrun, srp, sfs, svs;

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'(i));
        chk("reset_blank_n", 64'(b_bn), 64'd0);
        chk("reset_hs", 64'(b_hs), 64'd0);
        chk("reset_rgb", 64'({b_r, b_g, b_b}), 64'd0);

        // Alignment and colour expansion on the first pixels of the frame.
        cycle(1'b0, 1'b1, 16'h1234);
        chk("first_read_pixel", 64'(b_rp), 64'd1);
        cycle(1'b0, 1'b1, 16'h1234);
        chk("blank_n_before_rise", 64'(b_bn), 64'd0);
        cycle(1'b0, 1'b1, 16'h7FFF);
        chk("blank_n_rise", 64'(b_bn), 64'd1);
        chk("colour_white", 64'({b_r, b_g, b_b}), 64'({10'h3FF, 10'h3FF, 10'h3FF}));
        cycle(1'b0, 1'b1, 16'h7C00);
        chk("colour_red", 64'({b_r, b_g, b_b}), 64'({10'h3FF, 10'h000, 10'h000}));
        cycle(1'b0, 1'b1, 16'h0421);
        chk("colour_lsb", 64'({b_r, b_g, b_b}), 64'({10'h021, 10'h021, 10'h021}));

        // Aggregate line/frame counts over a clean enabled stretch.
        bhs = 0; brp = 0; run = 0; maxrun = 0; srp = 0; sfs = 0; svs = 0;
        brp = 5; run = 5; maxrun = 5; srp = 5;
        for (int i = 0; i < 3600; i++) begin
            cycle(1'b0, 1'b1, 16'($urandom()));
            if (t < 3168) begin
                bhs += int'(b_hs);
                brp += int'(b_rp);
                run = b_rp ? run + 1 : 0;
                if (run > maxrun) maxrun = run;
            end
            if (t < 29 * 120) begin
                srp += int'(s_rp);
                sfs += int'(s_fs);
            end
            if (t >= 2 && t < 29 * 120 + 2) svs += int'(s_vs);
        end
        chk("hs_cycles_3_lines", 64'(bhs), 64'd384);
        chk("read_pixel_3_lines", 64'(brp), 64'd2400);
        chk("read_pixel_run", 64'(maxrun), 64'd800);
        chk("small_pixels_29_frames", 64'(srp), 64'(29 * 32));
        chk("small_frame_start_29", 64'(sfs), 64'd29);
        chk("small_vs_cycles_29", 64'(svs), 64'(29 * 30));

        // Reset mid-line, then restart.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 16'($urandom()));
        chk("midline_reset_rp", 64'(b_rp), 64'd0);
        chk("midline_reset_bn", 64'(s_bn), 64'd0);
        for (int i = 0; i < 2000; i++) cycle(1'b0, 1'b1, 16'($urandom()));

        // Disabled: no frame_start, outputs parked.
        sfs = 0;
        for (int i = 0; i < 200; i++) begin
            cycle(1'b0, 1'b0, 16'($urandom()));
            sfs += int'(s_fs) + int'(s_rp);
        end
        chk("disabled_quiet", 64'(sfs), 64'd0);

        // Long random run with occasional enable drops.
        for (int i = 0; i < 40000; i++)
            cycle(1'b0, ($urandom_range(0, 1999) != 0), 16'($urandom()));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
